// File: rtl/pstprc_iq_framer_if.sv
// Frame output stream of the IQ framer: 32-bit words with valid/ready/last.
// The master side (framer) drives data/valid/last; the slave side returns ready.
interface pstprc_iq_framer_if;
    logic [31:0] frm_data_o;
    logic        frm_valid_o;
    logic        frm_last_o;
    logic        frm_ready_i;

    modport master (
        output frm_data_o,
        output frm_valid_o,
        output frm_last_o,
        input  frm_ready_i
    );

    modport slave (
        input  frm_data_o,
        input  frm_valid_o,
        input  frm_last_o,
        output frm_ready_i
    );
endinterface

// File: rtl/pstprc_iq_framer.sv
// pstprc_iq_framer
// Buffers the 64-bit IQ results written by the demodulation segment and, on
// Pstprc_finish, streams them out as one frame: header, then I/Q word pairs,
// then an optional XOR checksum word.
// Optional feature: define IQ_CHKSUM_EN to append the checksum word (CHK state).
module pstprc_iq_framer #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] FRAME_HDR  = 16'hEB90
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pstprc_num_en,
    input  logic [3:0]                Pstprc_num,
    input  logic                      pstprc_fifo_wren,
    input  logic [63:0]               pstprc_IQ_seq_o,
    input  logic                      Pstprc_finish,
    input  logic                      err_clr,
    pstprc_iq_framer_if.master        frm,
    output logic                      frm_busy_o,
    output logic [1:0]                err_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] q;
    } iq_t;

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        HDR     = 3'd1,
        DAT_I   = 3'd2,
        DAT_Q   = 3'd3
`ifdef IQ_CHKSUM_EN
        , CHK   = 3'd4
`endif
    } state_t;

    state_t      state, state_nxt;
    iq_t         mem [FIFO_DEPTH];
    iq_t         head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [4:0]  rcv_cnt, rcv_cnt_nxt;
    logic [7:0]  seq;
    logic [3:0]  exp_num;
    logic        mism_q;
    logic        full, last_entry, in_collect;
    logic        push, pop, accept, frame_end;
    logic [1:0]  err_set;
    logic [31:0] data_w;
    logic        valid_w, last_w;
`ifdef IQ_CHKSUM_EN
    logic [31:0] chk_acc;
`endif

    assign in_collect  = (state == COLLECT);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign last_entry  = ((rd_ptr + PTR_ONE) == wr_ptr);
    assign head        = mem[rd_ptr[AW-1:0]];
    assign push        = pstprc_fifo_wren && in_collect && !full;
    assign accept      = valid_w && frm.frm_ready_i;
    assign pop         = accept && (state == DAT_Q);
    assign frame_end   = accept && last_w;
    assign rcv_cnt_nxt = rcv_cnt + {4'd0, push};

    // Words arriving outside COLLECT or into a full FIFO are lost; a finish
    // pulse arriving mid-frame is lost.
    assign err_set[0]  = pstprc_fifo_wren && (!in_collect || full);
    assign err_set[1]  = Pstprc_finish && !in_collect;

    assign frm.frm_data_o  = data_w;
    assign frm.frm_valid_o = valid_w;
    assign frm.frm_last_o  = last_w;
    assign frm_busy_o      = !in_collect;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    // Next state and frame word mux; outputs depend only on registered state,
    // so they stay stable while the downstream stalls.
    always_comb begin
        state_nxt = state;
        valid_w   = 1'b0;
        last_w    = 1'b0;
        data_w    = '0;
        case (state)
            COLLECT: begin
                if (Pstprc_finish) state_nxt = HDR;
            end
            HDR: begin
                valid_w = 1'b1;
                data_w  = {FRAME_HDR, seq, mism_q, 2'b00, rcv_cnt};
`ifdef IQ_CHKSUM_EN
                if (accept) state_nxt = (rcv_cnt == 5'd0) ? CHK : DAT_I;
`else
                last_w  = (rcv_cnt == 5'd0);
                if (accept) state_nxt = (rcv_cnt == 5'd0) ? COLLECT : DAT_I;
`endif
            end
            DAT_I: begin
                valid_w = 1'b1;
                data_w  = head.i;
                if (accept) state_nxt = DAT_Q;
            end
            DAT_Q: begin
                valid_w = 1'b1;
                data_w  = head.q;
`ifdef IQ_CHKSUM_EN
                if (accept) state_nxt = last_entry ? CHK : DAT_I;
`else
                last_w  = last_entry;
                if (accept) state_nxt = last_entry ? COLLECT : DAT_I;
`endif
            end
`ifdef IQ_CHKSUM_EN
            CHK: begin
                valid_w = 1'b1;
                last_w  = 1'b1;
                data_w  = chk_acc;
                if (accept) state_nxt = COLLECT;
            end
`endif
            default: state_nxt = COLLECT;
        endcase
    end

    // FIFO storage; contents need no reset since pointers qualify them
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= iq_t'(pstprc_IQ_seq_o);
    end

    // FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Expected result count
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                exp_num <= '0;
        else if (pstprc_num_en) exp_num <= Pstprc_num;
    end

    // Received count and frame sequence number; mismatch flag is frozen at
    // finish so a later exp_num update cannot disturb a stalled header.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcv_cnt <= '0;
            seq     <= '0;
            mism_q  <= 1'b0;
        end else begin
            if (frame_end) begin
                rcv_cnt <= '0;
                seq     <= seq + 8'd1;
            end else begin
                rcv_cnt <= rcv_cnt_nxt;
            end
            if (in_collect && Pstprc_finish) mism_q <= (rcv_cnt_nxt != {1'b0, exp_num});
        end
    end

    // Sticky error flags; a new event in the clear cycle survives the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_o <= '0;
        else     err_o <= (err_o & ~{2{err_clr}}) | err_set;
    end

`ifdef IQ_CHKSUM_EN
    // Running XOR of every accepted word of the current frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            chk_acc <= '0;
        else if (frame_end) chk_acc <= '0;
        else if (accept)    chk_acc <= chk_acc ^ data_w;
    end
`endif

endmodule

// File: tb/tb_pstprc_iq_framer.sv
// Directed bench for pstprc_iq_framer: framing, backpressure, overflow,
// mid-frame finish, mid-frame reset.
module tb_pstprc_iq_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pstprc_num_en = 1'b0;
    logic [3:0]  Pstprc_num = '0;
    logic        pstprc_fifo_wren = 1'b0;
    logic [63:0] pstprc_IQ_seq_o = '0;
    logic        Pstprc_finish = 1'b0;
    logic        err_clr = 1'b0;
    logic        frm_busy_o;
    logic [1:0]  err_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_words[$];

    always #5 clk = ~clk;

    pstprc_iq_framer_if frm_if ();

    pstprc_iq_framer #(.FIFO_DEPTH(16), .FRAME_HDR(16'hEB90)) dut (
        .clk              (clk),
        .rst              (rst),
        .pstprc_num_en    (pstprc_num_en),
        .Pstprc_num       (Pstprc_num),
        .pstprc_fifo_wren (pstprc_fifo_wren),
        .pstprc_IQ_seq_o  (pstprc_IQ_seq_o),
        .Pstprc_finish    (Pstprc_finish),
        .err_clr          (err_clr),
        .frm              (frm_if.master),
        .frm_busy_o       (frm_busy_o),
        .err_o            (err_o)
    );

    task automatic drive(input bit we, input logic [63:0] d, input bit fin,
                         input bit nen, input logic [3:0] n, input bit clr);
        @(negedge clk);
        pstprc_fifo_wren = we;
        pstprc_IQ_seq_o  = d;
        Pstprc_finish    = fin;
        pstprc_num_en    = nen;
        Pstprc_num       = n;
        err_clr          = clr;
    endtask

    task automatic idle();
        drive(1'b0, 64'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic add_chk();
`ifdef IQ_CHKSUM_EN
        logic [31:0] x;
        x = '0;
        foreach (exp_words[k]) x ^= exp_words[k];
        exp_words.push_back(x);
`endif
    endtask

    // Drain one frame, comparing each accepted word against exp_words.
    task automatic run_frame(input bit rnd, input bit chk_lat, input string nm);
        int got, cyc, n;
        bit done, stalled, r;
        logic [31:0] pdata;
        logic plast;
        got = 0; cyc = 0; done = 0; stalled = 0; pdata = '0; plast = 1'b0;
        n = exp_words.size();
        while (!done && cyc < 400) begin
            idle();
            if (chk_lat && cyc == 0) begin
                n_cmp++;
                if (frm_if.frm_valid_o !== 1'b1 || frm_busy_o !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s latency: valid=%b busy=%b, want 1/1", nm, frm_if.frm_valid_o, frm_busy_o);
                end
            end
            if (stalled) begin
                n_cmp++;
                if (frm_if.frm_valid_o !== 1'b1 || frm_if.frm_data_o !== pdata || frm_if.frm_last_o !== plast) begin
                    n_bad++;
                    $display("FAIL %s stall_hold: valid=%b data=%h last=%b, want 1 %h %b", nm,
                             frm_if.frm_valid_o, frm_if.frm_data_o, frm_if.frm_last_o, pdata, plast);
                end
            end
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            frm_if.frm_ready_i = r;
            if (frm_if.frm_valid_o === 1'b1 && r) begin
                n_cmp++;
                if (got >= n) begin
                    n_bad++;
                    $display("FAIL %s extra_word: got %h beyond %0d words", nm, frm_if.frm_data_o, n);
                end else if (frm_if.frm_data_o !== exp_words[got] || frm_if.frm_last_o !== logic'(got == n - 1)) begin
                    n_bad++;
                    $display("FAIL %s word%0d: data=%h last=%b, want %h %b", nm, got,
                             frm_if.frm_data_o, frm_if.frm_last_o, exp_words[got], logic'(got == n - 1));
                end
                if (frm_if.frm_last_o === 1'b1) done = 1;
                got++;
            end
            stalled = (frm_if.frm_valid_o === 1'b1) && !r;
            pdata   = frm_if.frm_data_o;
            plast   = frm_if.frm_last_o;
            cyc++;
        end
        n_cmp++;
        if (!done || got != n) begin
            n_bad++;
            $display("FAIL %s word_count: got %0d (last seen %0b), want %0d", nm, got, done, n);
        end
    endtask

    task automatic check_idle(input string nm, input logic [1:0] exp_err);
        n_cmp++;
        if (frm_if.frm_valid_o !== 1'b0 || frm_busy_o !== 1'b0 || err_o !== exp_err) begin
            n_bad++;
            $display("FAIL %s idle: valid=%b busy=%b err=%b, want 0 0 %b", nm,
                     frm_if.frm_valid_o, frm_busy_o, err_o, exp_err);
        end
    endtask

    task automatic test_reset();
        frm_if.frm_ready_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (frm_if.frm_data_o !== 32'd0 || frm_if.frm_last_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_data: data=%h last=%b, want 0 0", frm_if.frm_data_o, frm_if.frm_last_o);
        end
        check_idle("reset", 2'b00);
        rst = 1'b0;
    endtask

    // T1: three results, one arriving with the finish pulse
    task automatic test_basic();
        drive(1'b0, 64'd0, 1'b0, 1'b1, 4'd3, 1'b0);
        drive(1'b1, {32'd1, 32'hFFFF_FFFF}, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b1, {32'd2, 32'hFFFF_FFFE}, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b1, {32'd3, 32'hFFFF_FFFD}, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_words = '{32'hEB90_0003, 32'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFD};
        add_chk();
        run_frame(1'b0, 1'b1, "t1");
        idle();
        check_idle("t1_end", 2'b00);
    endtask

    // T4: same payload, random backpressure, second frame so seq=1
    task automatic test_backpressure();
        drive(1'b0, 64'd0, 1'b0, 1'b1, 4'd3, 1'b0);
        drive(1'b1, {32'd1, 32'hFFFF_FFFF}, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b1, {32'd2, 32'hFFFF_FFFE}, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b1, {32'd3, 32'hFFFF_FFFD}, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 64'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_words = '{32'hEB90_0103, 32'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFD};
        add_chk();
        run_frame(1'b1, 1'b1, "t4");
        idle();
        check_idle("t4_end", 2'b00);
    endtask

    // T2: finish with nothing collected, seq=2
    task automatic test_empty();
        drive(1'b0, 64'd0, 1'b0, 1'b1, 4'd0, 1'b0);
        drive(1'b0, 64'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_words = '{32'hEB90_0200};
        add_chk();
        run_frame(1'b0, 1'b1, "t2");
        idle();
        check_idle("t2_end", 2'b00);
    endtask

    // T3: 17 writes into a 16-deep FIFO, count mismatch against 15, seq=3
    task automatic test_overflow();
        drive(1'b0, 64'd0, 1'b0, 1'b1, 4'd15, 1'b0);
        for (int k = 0; k < 17; k++)
            drive(1'b1, {32'(k + 1), ~32'(k)}, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 64'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_words = '{32'hEB90_0390};
        for (int k = 0; k < 16; k++) begin
            exp_words.push_back(32'(k + 1));
            exp_words.push_back(~32'(k));
        end
        add_chk();
        run_frame(1'b0, 1'b1, "t3");
        idle();
        check_idle("t3_end", 2'b01);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 4'd0, 1'b1);
        idle();
        check_idle("t3_clr", 2'b00);
    endtask

    // T5: finish and write during DAT_I are both lost, frame completes, seq=4
    task automatic test_finish_in_frame();
        drive(1'b0, 64'd0, 1'b0, 1'b1, 4'd2, 1'b0);
        drive(1'b1, {32'd10, 32'd20}, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b1, {32'd11, 32'd21}, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 64'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        idle();
        n_cmp++;
        if (frm_if.frm_valid_o !== 1'b1 || frm_if.frm_data_o !== 32'hEB90_0402) begin
            n_bad++;
            $display("FAIL t5_hdr: valid=%b data=%h, want 1 eb900402", frm_if.frm_valid_o, frm_if.frm_data_o);
        end
        frm_if.frm_ready_i = 1'b1;
        idle();
        n_cmp++;
        if (frm_if.frm_data_o !== 32'd10) begin
            n_bad++;
            $display("FAIL t5_dat_i: data=%h, want 0000000a", frm_if.frm_data_o);
        end
        frm_if.frm_ready_i = 1'b0;
        pstprc_fifo_wren   = 1'b1;
        pstprc_IQ_seq_o    = {32'd99, 32'd98};
        Pstprc_finish      = 1'b1;
        idle();
        n_cmp++;
        if (err_o !== 2'b11 || frm_if.frm_data_o !== 32'd10 || frm_if.frm_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL t5_err: err=%b data=%h valid=%b, want 11 0000000a 1", err_o, frm_if.frm_data_o, frm_if.frm_valid_o);
        end
        exp_words = '{32'hEB90_0402, 32'd10, 32'd20, 32'd11, 32'd21};
        add_chk();
        void'(exp_words.pop_front());
        run_frame(1'b0, 1'b0, "t5");
        idle();
        idle();
        check_idle("t5_end", 2'b11);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 4'd0, 1'b1);
        idle();
        check_idle("t5_clr", 2'b00);
    endtask

    // T6: reset during DAT_Q of frame seq=5, then a fresh frame from seq=0
    task automatic test_reset_mid_frame();
        drive(1'b0, 64'd0, 1'b0, 1'b1, 4'd2, 1'b0);
        drive(1'b1, {32'd5, 32'd6}, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b1, {32'd7, 32'd8}, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 64'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        idle();
        frm_if.frm_ready_i = 1'b1;
        idle();
        idle();
        n_cmp++;
        if (frm_if.frm_valid_o !== 1'b1 || frm_if.frm_data_o !== 32'd6) begin
            n_bad++;
            $display("FAIL t6_dat_q: valid=%b data=%h, want 1 00000006", frm_if.frm_valid_o, frm_if.frm_data_o);
        end
        frm_if.frm_ready_i = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (frm_if.frm_valid_o !== 1'b0 || frm_if.frm_data_o !== 32'd0 ||
            frm_if.frm_last_o !== 1'b0 || frm_busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL t6_async_rst: valid=%b data=%h last=%b busy=%b, want 0 0 0 0",
                     frm_if.frm_valid_o, frm_if.frm_data_o, frm_if.frm_last_o, frm_busy_o);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b1, 4'd1, 1'b0);
        drive(1'b1, {32'd9, 32'd10}, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 64'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_words = '{32'hEB90_0001, 32'd9, 32'd10};
        add_chk();
        run_frame(1'b0, 1'b1, "t6");
        idle();
        check_idle("t6_end", 2'b00);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_overflow();
        test_finish_in_frame();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
